// File: rtl/wisc_pkg.sv
// Shared types for the 16-bit pipelined core: forward-select encoding,
// halt FSM states and the per-stage tracking entry used by the hazard logic.
package wisc_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EXM = 2'b01,
        FWD_MWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } halt_state_t;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [3:0] dst;
        logic       is_load;
        logic       hlt;
    } pipe_ent_t;

    localparam pipe_ent_t PIPE_BUBBLE = pipe_ent_t'(8'h00);

    // R0 is hard-wired, so a write to it can never be a dependency.
    function automatic logic src_match(input logic re, input logic [3:0] addr,
                                       input pipe_ent_t ent);
        return re & ent.valid & ent.we & (ent.dst == addr) & (addr != 4'd0);
    endfunction

endpackage

// File: rtl/hazard_pipe_track.sv
// Shadow of the EX/MEM/WB destinations: shifts every cycle, takes either the
// ID entry or a bubble into EX, and reports per-stage source matches.
module hazard_pipe_track
    import wisc_pkg::*;
#(
    parameter int NSTG = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  pipe_ent_t       id_ent,
    input  logic [3:0]      p0_addr,
    input  logic [3:0]      p1_addr,
    input  logic            re0,
    input  logic            re1,
    output logic            ex_is_load,
    output logic [NSTG-1:0] match0,
    output logic [NSTG-1:0] match1
);

    pipe_ent_t pipe_q [NSTG];
    pipe_ent_t pipe_d [NSTG];

    // Next-state of the shift pipe: index 0 is EX, NSTG-1 is WB.
    always_comb begin
        for (int i = 0; i < NSTG; i++) begin
            pipe_d[i] = PIPE_BUBBLE;
        end
        if (load_en) begin
            pipe_d[0] = id_ent;
        end else begin
            pipe_d[0] = PIPE_BUBBLE;
        end
        for (int i = 1; i < NSTG; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipe registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) begin
                pipe_q[i] <= PIPE_BUBBLE;
            end
        end else begin
            for (int i = 0; i < NSTG; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Per-stage dependency flags for both ID source operands.
    always_comb begin
        match0 = '0;
        match1 = '0;
        for (int i = 0; i < NSTG; i++) begin
            match0[i] = src_match(re0, p0_addr, pipe_q[i]);
            match1[i] = src_match(re1, p1_addr, pipe_q[i]);
        end
        ex_is_load = pipe_q[0].valid & pipe_q[0].is_load;
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: load-use stall, registered EX forward
// selects, and the end-of-program halt sequencing toward the register file.
module id_hazard_ctrl
    import wisc_pkg::*;
#(
    parameter int NSTG = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [3:0] id_p0_addr,
    input  logic [3:0] id_p1_addr,
    input  logic       id_re0,
    input  logic       id_re1,
    input  logic [3:0] id_dst_addr,
    input  logic       id_we,
    input  logic       id_is_load,
    input  logic       id_hlt,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] ex_fwd0,
    output logic [1:0] ex_fwd1,
    output logic       hlt_out
);

    halt_state_t     state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    fwd_sel_t        ex_fwd0_q, ex_fwd0_d;
    fwd_sel_t        ex_fwd1_q, ex_fwd1_d;
    logic            hlt_out_q, hlt_out_d;
    logic            load_en;
    logic            ex_is_load;
    logic [NSTG-1:0] match0, match1;
    pipe_ent_t       id_ent;

    // WB producers are covered by the register file's write-then-read cycle.
    function automatic fwd_sel_t pick_sel(input logic m_ex, input logic m_mem,
                                          input logic m_wb);
        fwd_sel_t sel;
        if (m_ex) begin
            sel = FWD_EXM;
        end else if (m_mem) begin
            sel = FWD_MWB;
        end else if (m_wb) begin
            sel = FWD_RF;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    hazard_pipe_track #(.NSTG(NSTG)) u_track (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .id_ent     (id_ent),
        .p0_addr    (id_p0_addr),
        .p1_addr    (id_p1_addr),
        .re0        (id_re0),
        .re1        (id_re1),
        .ex_is_load (ex_is_load),
        .match0     (match0),
        .match1     (match1)
    );

    // Stall, EX admission, forward selects and halt FSM next-state.
    always_comb begin
        id_ent.valid   = 1'b1;
        id_ent.we      = id_we & ~id_hlt;
        id_ent.dst     = id_dst_addr;
        id_ent.is_load = id_is_load;
        id_ent.hlt     = id_hlt;

        if (state_q != RUN) begin
            stall = 1'b1;
        end else begin
            stall = id_valid & ~flush & ex_is_load & (match0[0] | match1[0]);
        end
        load_en = id_valid & ~stall & ~flush;

        if (load_en) begin
            ex_fwd0_d = pick_sel(match0[0], match0[1], match0[2]);
            ex_fwd1_d = pick_sel(match1[0], match1[1], match1[2]);
        end else begin
            ex_fwd0_d = FWD_RF;
            ex_fwd1_d = FWD_RF;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (load_en & id_hlt) begin
                    state_d = DRAIN;
                    cnt_d   = 2'd2;
                end else begin
                    state_d = RUN;
                end
            end
            // Counter tracks the HLT through EX, MEM, WB; zero means it is in WB.
            DRAIN: begin
                if (cnt_q == 2'd0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
        hlt_out_d = (state_d == HALTED);
    end

    // Registered state and outputs, synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= 2'd0;
            ex_fwd0_q <= FWD_RF;
            ex_fwd1_q <= FWD_RF;
            hlt_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ex_fwd0_q <= ex_fwd0_d;
            ex_fwd1_q <= ex_fwd1_d;
            hlt_out_q <= hlt_out_d;
        end
    end

    assign ex_fwd0 = ex_fwd0_q;
    assign ex_fwd1 = ex_fwd1_q;
    assign hlt_out = hlt_out_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed scoreboard bench for id_hazard_ctrl: each step queues the expected
// outputs for its cycle, and a negedge monitor pops and compares them.
module tb_id_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_p0_addr, id_p1_addr;
    logic       id_re0, id_re1;
    logic [3:0] id_dst_addr;
    logic       id_we, id_is_load, id_hlt, flush;
    logic       stall;
    logic [1:0] ex_fwd0, ex_fwd1;
    logic       hlt_out;

    typedef struct {
        int         id;
        logic       st;
        logic [1:0] f0;
        logic [1:0] f1;
        logic       h;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   vectors;
    int   miscompares;
    int   step_no;

    id_hazard_ctrl #(.NSTG(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_p0_addr  (id_p0_addr),
        .id_p1_addr  (id_p1_addr),
        .id_re0      (id_re0),
        .id_re1      (id_re1),
        .id_dst_addr (id_dst_addr),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .id_hlt      (id_hlt),
        .flush       (flush),
        .stall       (stall),
        .ex_fwd0     (ex_fwd0),
        .ex_fwd1     (ex_fwd1),
        .hlt_out     (hlt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of ID inputs and queue the outputs expected in that cycle.
    task automatic step(input logic r, input logic v, input logic [3:0] p0,
                        input logic [3:0] p1, input logic re0, input logic re1,
                        input logic [3:0] dst, input logic we, input logic ld,
                        input logic hl, input logic fl, input logic e_st,
                        input logic [1:0] e_f0, input logic [1:0] e_f1,
                        input logic e_h);
        exp_t e;
        rst = r; id_valid = v; id_p0_addr = p0; id_p1_addr = p1;
        id_re0 = re0; id_re1 = re1; id_dst_addr = dst; id_we = we;
        id_is_load = ld; id_hlt = hl; flush = fl;
        step_no++;
        e.id = step_no; e.st = e_st; e.f0 = e_f0; e.f1 = e_f1; e.h = e_h;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r, input logic e_st, input logic [1:0] e_f0,
                        input logic [1:0] e_f1, input logic e_h);
        step(r, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0,
             e_st, e_f0, e_f1, e_h);
    endtask

    // Monitor: compare every output against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            vectors = vectors + 4;
            if (stall !== cur.st) begin
                miscompares++;
                $display("FAIL s%0d stall: got %b want %b", cur.id, stall, cur.st);
            end
            if (ex_fwd0 !== cur.f0) begin
                miscompares++;
                $display("FAIL s%0d ex_fwd0: got %b want %b", cur.id, ex_fwd0, cur.f0);
            end
            if (ex_fwd1 !== cur.f1) begin
                miscompares++;
                $display("FAIL s%0d ex_fwd1: got %b want %b", cur.id, ex_fwd1, cur.f1);
            end
            if (hlt_out !== cur.h) begin
                miscompares++;
                $display("FAIL s%0d hlt_out: got %b want %b", cur.id, hlt_out, cur.h);
            end
        end
    end

    initial begin
        vectors = 0; miscompares = 0; step_no = 0;
        rst = 1'b1; id_valid = 1'b0; id_p0_addr = 4'd0; id_p1_addr = 4'd0;
        id_re0 = 1'b0; id_re1 = 1'b0; id_dst_addr = 4'd0; id_we = 1'b0;
        id_is_load = 1'b0; id_hlt = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        idle(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        // ADD R1 <- R2,R3 ; ADD R2 <- R1,R1 back to back
        step(1'b0, 1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 1'b1, 4'd1, 4'd1, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        idle(1'b0, 1'b0, 2'b01, 2'b01, 1'b0);
        idle(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        // LW R3 ; ADD R4 <- R3,R5 : one stall cycle, then MEM/WB forward
        step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        step(1'b0, 1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        idle(1'b0, 1'b0, 2'b10, 2'b00, 1'b0);
        idle(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        // ADD R6 ; ADD R6 ; SUB R8 <- R6,R5 : newer producer wins
        step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 1'b1, 4'd6, 4'd5, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        idle(1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
        // ADD R0 ; ADD R9 <- R0,R0 ; ADD R10 with re=0 reading R9
        step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        // LW R7 ; flushed dependent : no stall, bubble enters EX
        step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 1'b1, 4'd7, 4'd7, 1'b1, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        idle(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        idle(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        // ADD R1 ; HLT accepted at edge N ; hlt_out at N+3
        step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 1'b1, 4'd1, 4'd1, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        idle(1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        idle(1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        idle(1'b0, 1'b1, 2'b00, 2'b00, 1'b1);
        // reset from HALTED
        idle(1'b1, 1'b1, 2'b00, 2'b00, 1'b1);
        idle(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        // HLT then reset while in DRAIN, then normal forwarding resumes
        step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        idle(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
        step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        idle(1'b0, 1'b0, 2'b01, 2'b00, 1'b0);

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Decode-stage hazard controller for the 16-bit pipelined core. It sits directly upstream of the register file, alongside the ID-stage operand read, and tracks the destinations of instructions in EX, MEM and WB. From that it generates the load-use stall, registered operand-forwarding selects for EX, and the end-of-program `hlt` pulse that drives the register file's dump input once the final write has committed. The register file writes on clock high and reads on clock low in the same cycle, so a WB-stage producer never needs a bypass.

## Interface
Parameters:
- `NSTG`, 3: tracked stages beyond ID (EX, MEM, WB); fixed for this core.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `id_valid`  in  1  a real instruction is in ID
- `id_p0_addr`, `id_p1_addr`  in  4 each  source register addresses (the same nets feed the register file)
- `id_re0`, `id_re1`  in  1 each  source used
- `id_dst_addr`  in  4  destination register
- `id_we`  in  1  instruction writes `id_dst_addr`
- `id_is_load`  in  1  result available only at the end of MEM
- `id_hlt`  in  1  instruction is HLT
- `flush`  in  1  squash the instruction in ID
- `stall`  out  1  hold PC and IF/ID; insert a bubble into EX (combinational)
- `ex_fwd0`, `ex_fwd1`  out  2 each  EX operand source: 00 = RF, 01 = EX/MEM result, 10 = MEM/WB result (registered)
- `hlt_out`  out  1  to the register file `hlt`; rises once the HLT has left WB (registered)

## Operation
- The tracker holds a 3-entry shift pipe, EX→MEM→WB, with fields {valid, we, dst, is_load, hlt}. It advances every cycle.
- ID entry loaded into EX: the ID fields when `id_valid & ~stall & ~flush`; otherwise a bubble (valid=0).
- A source matches a producer when:
  - the source's `re` is set,
  - the producer is valid and `we=1`,
  - the producer's `dst` equals the source address,
  - and the source address ≠ 0.
- R0 never creates a hazard.
- Load-use: `stall = id_valid & ~flush & (either source matches the EX entry with is_load=1)`. A stall lasts exactly 1 cycle per load.
- Forward selects are computed for the ID instruction against the EX and MEM entries. They are registered into `ex_fwd*` when the instruction advances, so they are valid during its EX cycle.
  - Match against the EX entry → 01.
  - Else match against the MEM entry → 10.
  - Else → 00.
  - A match against the WB entry → 00, because the register file bypasses it internally.
  - When both EX and MEM match, the newer producer (EX) wins.
  - After a load-use stall, the load is in WB when the consumer reaches EX, so the select is 10.
- Selects are registered as 00 whenever a bubble enters EX.
- Halt FSM:
  - RUN → DRAIN when an entry with hlt=1 is loaded into EX. The HLT's own `we` is ignored.
  - DRAIN → HALTED when that entry leaves WB. A 2-bit down-counter is loaded with 2 on entry to DRAIN.
  - HALTED is terminal until `rst`.
- In DRAIN and HALTED, `stall=1` and bubbles are inserted; ID is frozen.
- `hlt_out` = 1 only in HALTED.

## Timing
- Reset state: FSM = RUN; all pipe entries invalid; `ex_fwd0/1` = 00; `hlt_out` = 0; `stall` = 0 (no valid EX entry).
- `stall` settles in the same cycle from ID inputs and registered state. There is no path from `stall` back into its own inputs.
- `ex_fwd*` and `hlt_out` change only on `clk` rising edges.
- HLT accepted at edge N (enters EX):
  - EX cycle N, MEM N+1, WB N+2.
  - `hlt_out` rises at edge N+3 and stays high.
- `flush` together with `stall`: `flush` wins, `stall`=0, bubble enters EX.
- `flush` together with `id_hlt`: the HLT is squashed and the FSM stays RUN.
- `rst` mid-operation clears the pipe, FSM and outputs at the next edge, including from HALTED.
- `id_valid=0`: behaves like a bubble; `stall`=0.

## Structure
- Shared package `wisc_pkg`:
  - `fwd_sel_t` encoding {FWD_RF = 2'b00, FWD_EXM = 2'b01, FWD_MWB = 2'b10}
  - `halt_state_t` {RUN, DRAIN, HALTED}
  - `pipe_ent_t` struct {valid, we, dst[3:0], is_load, hlt}
- One sub-module, `hazard_pipe_track`: the 3-entry shift pipe with bubble insertion and per-stage match outputs for two source addresses.
- The FSM and select encoding stay in `id_hazard_ctrl`.

## Test plan
- ADD R1 ← …, then ADD R2 ← R1,R1 back to back → `stall`=0; `ex_fwd0`=`ex_fwd1`=01 in the consumer's EX cycle.
- LW R3, then ADD R4 ← R3,R5 → `stall`=1 for exactly one cycle, one bubble; then `ex_fwd0`=10, `ex_fwd1`=00.
- ADD R6, ADD R6, then SUB ← R6 → `ex_fwd0`=01, because the newer producer wins over the MEM/WB match.
- Producer writes R0, or the consumer has `re`=0 → `stall`=0 and selects 00; LW R7 with `flush` on the dependent → no stall, bubble enters EX.
- ADD R1 ← …, then HLT accepted at edge N → `hlt_out`=0 through N+2 and 1 at N+3; the final R1 value has committed before the dump; `stall` stays high afterward.
- Assert `rst` in DRAIN and in HALTED → next edge: `hlt_out`=0, FSM RUN, all selects 00.
